// File: rtl/sha_state_pkg.sv
// SHA chaining-state shared types, IV constants and word-slice helper.
// Used by sha_state_accum and sha_word_acc.
package sha_state_pkg;

  localparam logic [255:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [255:0] SHA224_IV = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [31:0] sha_word(
    input logic [255:0] v,
    input int unsigned  i
  );
    return v[i*32 +: 32];
  endfunction

endpackage

// File: rtl/sha_word_acc.sv
// One chaining-state word: register with load and modular add.
// Reset value, load value and addend are supplied by the bank.
module sha_word_acc
  import sha_state_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] rst_val_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_val_i,
  input  logic              add_i,
  input  logic [WORD_W-1:0] add_val_i,
  output logic [WORD_W-1:0] q_o
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = load_val_i;
    end else if (add_i) begin
      word_d = word_q + add_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= rst_val_i;
    end else begin
      word_q <= word_d;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/sha_state_accum.sv
// SHA chaining-state bank: IV load, per-block word-wise add, block count.
// Define SHA_STATE_ALT_IV_EN to add iv_sel and the alternate IV on init.
module sha_state_accum
  import sha_state_pkg::*;
#(
  parameter int                          N_WORDS = 8,
  parameter int                          WORD_W  = 32,
  parameter int                          CNT_W   = 16,
  parameter logic [N_WORDS*WORD_W-1:0]   IV      = SHA256_IV,
  parameter logic [N_WORDS*WORD_W-1:0]   IV_ALT  = SHA224_IV
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init,
`ifdef SHA_STATE_ALT_IV_EN
  input  logic                        iv_sel,
`endif
  input  logic                        add_valid,
  output logic                        add_ready,
  input  logic [N_WORDS*WORD_W-1:0]   add_data,
  input  logic                        add_last,
  output logic [N_WORDS*WORD_W-1:0]   state_out,
  output logic [CNT_W-1:0]            block_cnt,
  output logic                        digest_valid
);

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dv_q;
  logic             dv_d;

  logic                      hs;
  logic                      alt_sel;
  logic [N_WORDS*WORD_W-1:0] load_val;

`ifdef SHA_STATE_ALT_IV_EN
  assign alt_sel = iv_sel;
`else
  assign alt_sel = 1'b0;
`endif

  assign load_val  = alt_sel ? IV_ALT : IV;
  assign add_ready = (state_q == ACCUM);
  // init takes priority: a coincident add is dropped
  assign hs        = add_valid & add_ready & ~init;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (init) state_d = ACCUM;
      end
      ACCUM: begin
        if (init) state_d = ACCUM;
        else if (hs && add_last) state_d = DONE;
      end
      DONE: begin
        if (init) state_d = ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    dv_d  = dv_q;
    if (init) begin
      cnt_d = '0;
      dv_d  = 1'b0;
    end else if (hs) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      if (add_last) dv_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
    end
  end

  for (genvar i = 0; i < N_WORDS; i++) begin : g_word
    sha_word_acc #(
      .WORD_W (WORD_W)
    ) u_word (
      .clk        (clk),
      .rst        (rst),
      .rst_val_i  (IV[i*WORD_W +: WORD_W]),
      .load_i     (init),
      .load_val_i (load_val[i*WORD_W +: WORD_W]),
      .add_i      (hs),
      .add_val_i  (add_data[i*WORD_W +: WORD_W]),
      .q_o        (state_out[i*WORD_W +: WORD_W])
    );
  end

  assign block_cnt    = cnt_q;
  assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha_state_accum.sv
// Directed self-checking bench for sha_state_accum.
// Narrow block counter so saturation is reachable quickly.
module tb_sha_state_accum;
  import sha_state_pkg::*;

  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         iv_sel;
  logic         add_valid;
  logic         add_ready;
  logic [255:0] add_data;
  logic         add_last;
  logic [255:0] state_out;
  logic [CW-1:0] block_cnt;
  logic         digest_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha_state_accum #(
    .CNT_W (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
`ifdef SHA_STATE_ALT_IV_EN
    .iv_sel       (iv_sel),
`endif
    .add_valid    (add_valid),
    .add_ready    (add_ready),
    .add_data     (add_data),
    .add_last     (add_last),
    .state_out    (state_out),
    .block_cnt    (block_cnt),
    .digest_valid (digest_valid)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] ones();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'h1;
    return v;
  endfunction

  initial begin
    rst = 1'b1; init = 1'b0; iv_sel = 1'b0;
    add_valid = 1'b0; add_data = '0; add_last = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_w0", sha_word(state_out, 0), 32'h6a09e667);
    check("rst_cnt", 32'(block_cnt), 32'd0);
    check("rst_rdy", 32'(add_ready), 32'd0);
    check("rst_dv", 32'(digest_valid), 32'd0);

    // ignored add in IDLE
    add_valid = 1'b1; add_data = ones();
    step();
    add_valid = 1'b0;
    check("idle_w0", sha_word(state_out, 0), 32'h6a09e667);

    init = 1'b1; step(); init = 1'b0;
    check("init_w0", sha_word(state_out, 0), 32'h6a09e667);
    check("init_w4", sha_word(state_out, 4), 32'h510e527f);
    check("init_cnt", 32'(block_cnt), 32'd0);
    check("init_rdy", 32'(add_ready), 32'd1);

    add_data = ones(); add_valid = 1'b1;
    step(); add_valid = 1'b0;
    check("add1_w0", sha_word(state_out, 0), 32'h6a09e668);
    check("add1_w7", sha_word(state_out, 7), 32'h5be0cd1a);
    check("add1_cnt", 32'(block_cnt), 32'd1);
    check("add1_dv", 32'(digest_valid), 32'd0);

    init = 1'b1; step(); init = 1'b0;
    add_data = '0; add_data[31:0] = 32'h95f61999;
    add_valid = 1'b1; step(); add_valid = 1'b0;
    check("wrap_w0", sha_word(state_out, 0), 32'h00000000);
    check("wrap_w1", sha_word(state_out, 1), 32'hbb67ae85);

    // held valid adds on every cycle in ACCUM
    init = 1'b1; step(); init = 1'b0;
    add_data = ones(); add_valid = 1'b1;
    step(); step(); add_valid = 1'b0;
    check("hold_w0", sha_word(state_out, 0), 32'h6a09e669);
    check("hold_cnt", 32'(block_cnt), 32'd2);

    add_valid = 1'b1; add_last = 1'b1;
    step(); add_valid = 1'b0; add_last = 1'b0;
    check("last_dv", 32'(digest_valid), 32'd1);
    check("last_rdy", 32'(add_ready), 32'd0);
    check("last_w0", sha_word(state_out, 0), 32'h6a09e66a);
    check("last_cnt", 32'(block_cnt), 32'd3);

    add_valid = 1'b1; step(); step(); add_valid = 1'b0;
    check("done_w0", sha_word(state_out, 0), 32'h6a09e66a);
    check("done_cnt", 32'(block_cnt), 32'd3);
    check("done_dv", 32'(digest_valid), 32'd1);

    init = 1'b1; step(); init = 1'b0;
    check("reinit_dv", 32'(digest_valid), 32'd0);
    check("reinit_rdy", 32'(add_ready), 32'd1);
    add_valid = 1'b1; step(); add_valid = 1'b0;
    check("mid_w0", sha_word(state_out, 0), 32'h6a09e668);
    init = 1'b1; add_valid = 1'b1; step();
    init = 1'b0; add_valid = 1'b0;
    check("race_w0", sha_word(state_out, 0), 32'h6a09e667);
    check("race_w7", sha_word(state_out, 7), 32'h5be0cd19);
    check("race_cnt", 32'(block_cnt), 32'd0);
    check("race_rdy", 32'(add_ready), 32'd1);

    add_valid = 1'b1; step();
    rst = 1'b1; step(); rst = 1'b0; add_valid = 1'b0;
    check("mrst_rdy", 32'(add_ready), 32'd0);
    check("mrst_w0", sha_word(state_out, 0), 32'h6a09e667);
    check("mrst_cnt", 32'(block_cnt), 32'd0);

    // counter saturates at 15, words keep adding
    init = 1'b1; step(); init = 1'b0;
    add_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    add_valid = 1'b0;
    check("sat_cnt", 32'(block_cnt), 32'd15);
    check("sat_w0", sha_word(state_out, 0), 32'h6a09e67b);

`ifdef SHA_STATE_ALT_IV_EN
    init = 1'b1; iv_sel = 1'b1; step(); init = 1'b0; iv_sel = 1'b0;
    check("alt_w0", sha_word(state_out, 0), 32'hc1059ed8);
    check("alt_w7", sha_word(state_out, 7), 32'hbefa4fa4);
    rst = 1'b1; step(); rst = 1'b0;
    check("alt_rst_w0", sha_word(state_out, 0), 32'h6a09e667);
`else
    init = 1'b1; iv_sel = 1'b1; step(); init = 1'b0; iv_sel = 1'b0;
    check("noalt_w0", sha_word(state_out, 0), 32'h6a09e667);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
